// File: rtl/keydec_pkg.sv
// rtl/keydec_pkg.sv - shared types and constants for the key decoder
package keydec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  localparam int unsigned HOLD_DEFAULT = 100;

  function automatic logic [15:0] decode4(input logic [3:0] c);
    decode4 = 16'h0001 << c;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer for strobe+code with strobe edge detect
module sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe_i,
  input  logic [3:0] code_i,
  output logic [3:0] code_o,
  output logic       rise,
  output logic       fall,
  output logic       level
);

  logic [4:0] s1_q, s1_d;
  logic [4:0] s2_q, s2_d;
  logic       s3_q, s3_d;

  always_comb begin
    s1_d = {strobe_i, code_i};
    s2_d = s1_q;
    s3_d = s2_q[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Code is taken from the s2 stage so it lines up with the detected edge.
  assign code_o = s2_q[3:0];
  assign level  = s2_q[4];
  assign rise   = s2_q[4] & ~s3_q;
  assign fall   = ~s2_q[4] & s3_q;

endmodule

// File: rtl/keydec4to16.sv
// rtl/keydec4to16.sv - key code to timed one-hot pulse with press counter and history
module keydec4to16
  import keydec_pkg::*;
#(
  parameter int unsigned HOLD = HOLD_DEFAULT
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [3:0]  code,
  input  logic        strobe,
  output logic [15:0] onehot,
  output logic        active,
  output logic [3:0]  last,
  output logic [7:0]  count,
  output logic [15:0] hist
);

  localparam logic [7:0] RELOAD = 8'(HOLD - 1);

  logic [3:0] code_s;
  logic       rise, fall, level;

  sync_edge u_sync (
    .clk      (hz100),
    .rst_n    (reset),
    .strobe_i (strobe),
    .code_i   (code),
    .code_o   (code_s),
    .rise     (rise),
    .fall     (fall),
    .level    (level)
  );

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [15:0] onehot_q, onehot_d;
  logic        active_q, active_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] hist_q, hist_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    onehot_d = onehot_q;
    active_d = active_q;
    last_d   = last_q;
    count_d  = count_q;
    hist_d   = hist_q;

    // A rise wins over timer expiry, which makes re-presses retrigger the pulse.
    if (rise && state_q != ST_WAIT_REL) begin
      state_d  = ST_HOLD;
      timer_d  = RELOAD;
      onehot_d = decode4(code_s);
      active_d = 1'b1;
      last_d   = code_s;
      count_d  = count_q + 8'd1;
      hist_d   = {hist_q[11:0], code_s};
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
          end else begin
            onehot_d = '0;
            active_d = 1'b0;
            state_d  = level ? ST_WAIT_REL : ST_IDLE;
          end
        end
        ST_WAIT_REL: begin
          if (fall) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      onehot_q <= '0;
      active_q <= 1'b0;
      last_q   <= '0;
      count_q  <= '0;
      hist_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      onehot_q <= onehot_d;
      active_q <= active_d;
      last_q   <= last_d;
      count_q  <= count_d;
      hist_q   <= hist_d;
    end
  end

  assign onehot = onehot_q;
  assign active = active_q;
  assign last   = last_q;
  assign count  = count_q;
  assign hist   = hist_q;

endmodule

// File: tb/tb_keydec4to16.sv
// tb/tb_keydec4to16.sv - randomized and directed check of keydec4to16 at HOLD 1, 4 and 8
module tb_keydec4to16;

  logic       hz100 = 1'b0;
  logic       reset = 1'b0;
  logic       strobe = 1'b0;
  logic [3:0] code = 4'h0;

  int total = 0;
  int bad = 0;

  always #5 hz100 = ~hz100;

  task automatic chk(input string nm, input int h, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s hold=%0d: got %h want %h", nm, h, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int H = (g == 0) ? 1 : ((g == 1) ? 4 : 8);

    logic [15:0] onehot, hist;
    logic        active;
    logic [3:0]  last;
    logic [7:0]  count;

    keydec4to16 #(.HOLD(H)) u_dut (
      .hz100  (hz100),
      .reset  (reset),
      .code   (code),
      .strobe (strobe),
      .onehot (onehot),
      .active (active),
      .last   (last),
      .count  (count),
      .hist   (hist)
    );

    // Model: p1..p3 are the input samples of the last three edges; each strobe
    // rise seen two edges late is a press, and the pulse lasts H edges from the latest press.
    logic [4:0]  p1 = '0, p2 = '0, p3 = '0;
    int          age = 1000;
    logic [3:0]  mcode = '0, mlast = '0;
    logic [7:0]  mcount = '0;
    logic [15:0] mhist = '0;
    logic [15:0] eoh;

    always @(posedge hz100 or negedge reset) begin
      if (!reset) begin
        p1 <= '0; p2 <= '0; p3 <= '0;
        age <= 1000; mcode <= '0; mlast <= '0; mcount <= '0; mhist <= '0;
      end else begin
        if (p2[4] && !p3[4]) begin
          mcode  <= p2[3:0];
          mlast  <= p2[3:0];
          mcount <= mcount + 8'd1;
          mhist  <= {mhist[11:0], p2[3:0]};
          age    <= 0;
        end else if (age < 1000) begin
          age <= age + 1;
        end
        p3 <= p2;
        p2 <= p1;
        p1 <= {strobe, code};
      end
    end

    always @(posedge hz100) begin
      #1;
      eoh = (age < H) ? (16'h0001 << mcode) : 16'h0000;
      chk("onehot", H, onehot, eoh);
      chk("active", H, {15'd0, active}, {15'd0, (age < H)});
      chk("last", H, {12'd0, last}, {12'd0, mlast});
      chk("count", H, {8'd0, count}, {8'd0, mcount});
      chk("hist", H, hist, mhist);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic press(input logic [3:0] c, input int hi, input int lo);
    code = c;
    strobe = 1'b1;
    cyc(hi);
    strobe = 1'b0;
    cyc(lo);
  endtask

  task automatic do_reset();
    @(negedge hz100);
    reset = 1'b0;
    strobe = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    cyc(3);
    chk("rst_onehot", 4, g_dut[1].onehot, 16'h0000);
    chk("rst_count", 4, {8'd0, g_dut[1].count}, 16'h0000);
    reset = 1'b1;

    // Asynchronous reset in the middle of a pulse with three presses counted.
    press(4'h1, 2, 6);
    press(4'h2, 2, 6);
    code = 4'h4;
    strobe = 1'b1;
    cyc(3);
    chk("pre_rst_onehot", 4, g_dut[1].onehot, 16'h0010);
    chk("pre_rst_count", 4, {8'd0, g_dut[1].count}, 16'h0003);
    #2 reset = 1'b0;
    #1;
    chk("async_onehot", 4, g_dut[1].onehot, 16'h0000);
    chk("async_active", 4, {15'd0, g_dut[1].active}, 16'h0000);
    chk("async_count", 4, {8'd0, g_dut[1].count}, 16'h0000);
    chk("async_hist", 4, g_dut[1].hist, 16'h0000);
    chk("async_last", 4, {12'd0, g_dut[1].last}, 16'h0000);
    @(negedge hz100);
    strobe = 1'b0;
    reset = 1'b1;
    cyc(4);
    chk("post_rst_onehot", 4, g_dut[1].onehot, 16'h0000);

    // Single press of key A held for ten cycles.
    code = 4'hA;
    strobe = 1'b1;
    repeat (3) @(posedge hz100);
    #1;
    chk("single_e2", 4, g_dut[1].onehot, 16'h0400);
    chk("single_e2_act", 4, {15'd0, g_dut[1].active}, 16'h0001);
    chk("h1_e2", 1, g_dut[0].onehot, 16'h0400);
    @(posedge hz100); #1;
    chk("h1_e3", 1, g_dut[0].onehot, 16'h0000);
    chk("h1_e3_act", 1, {15'd0, g_dut[0].active}, 16'h0000);
    repeat (2) @(posedge hz100); #1;
    chk("single_e5", 4, g_dut[1].onehot, 16'h0400);
    @(posedge hz100); #1;
    chk("single_e6", 4, g_dut[1].onehot, 16'h0000);
    @(negedge hz100);
    cyc(3);
    strobe = 1'b0;
    cyc(6);
    chk("single_last", 4, {12'd0, g_dut[1].last}, 16'h000A);
    chk("single_count", 4, {8'd0, g_dut[1].count}, 16'h0001);
    chk("single_hist", 4, g_dut[1].hist, 16'h000A);

    // Retrigger inside the HOLD=8 window.
    do_reset();
    code = 4'h3;
    strobe = 1'b1;
    cyc(2);
    strobe = 1'b0;
    cyc(2);
    code = 4'h5;
    strobe = 1'b1;
    @(posedge hz100);
    @(posedge hz100); #1;
    chk("retrig_e5", 8, g_dut[2].onehot, 16'h0008);
    @(posedge hz100); #1;
    chk("retrig_e6", 8, g_dut[2].onehot, 16'h0020);
    chk("retrig_count", 8, {8'd0, g_dut[2].count}, 16'h0002);
    chk("retrig_hist", 8, g_dut[2].hist, 16'h0035);
    repeat (7) @(posedge hz100); #1;
    chk("retrig_e13", 8, g_dut[2].onehot, 16'h0020);
    @(posedge hz100); #1;
    chk("retrig_e14", 8, g_dut[2].onehot, 16'h0000);
    @(negedge hz100);
    strobe = 1'b0;
    cyc(4);
    chk("retrig_count_end", 8, {8'd0, g_dut[2].count}, 16'h0002);

    // Code changes while strobe stays high.
    do_reset();
    code = 4'h2;
    strobe = 1'b1;
    cyc(3);
    code = 4'h7;
    cyc(5);
    strobe = 1'b0;
    cyc(4);
    chk("glitch_last", 4, {12'd0, g_dut[1].last}, 16'h0002);
    chk("glitch_count", 4, {8'd0, g_dut[1].count}, 16'h0001);

    // 260 presses wrap the counter.
    do_reset();
    for (int i = 0; i < 260; i++) press(4'(i % 4), 2, 2);
    cyc(4);
    chk("wrap_count", 4, {8'd0, g_dut[1].count}, 16'h0004);
    chk("wrap_hist", 4, g_dut[1].hist, 16'h0123);
    chk("wrap_count8", 8, {8'd0, g_dut[2].count}, 16'h0004);

    // Randomized strobe runs, code changes and occasional async resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge hz100);
      if ($urandom_range(0, 3) == 0) strobe = ~strobe;
      if ($urandom_range(0, 2) == 0) code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge hz100);
        reset = 1'b1;
      end
    end
    strobe = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
